voter_session: RTL and testbench

VOTER_SESSION -- requirements
Module: voter_session

---
 rtl/voter_pkg.sv | 32 +++
 rtl/voter_popcount.sv | 17 +
 rtl/voter_session.sv | 157 +++++++++++++++
 tb/tb_voter_session.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voter_pkg.sv
// Shared definitions for the voter_session block: state encoding, result class
// bit positions and the yes-count classification helper.
package voter_pkg;

  typedef enum logic [1:0] {
    VS_IDLE   = 2'd0,
    VS_OPEN   = 2'd1,
    VS_TALLY  = 2'd2,
    VS_RESULT = 2'd3
  } voter_state_e;

  localparam logic [1:0] ST_IDLE   = VS_IDLE;
  localparam logic [1:0] ST_OPEN   = VS_OPEN;
  localparam logic [1:0] ST_TALLY  = VS_TALLY;
  localparam logic [1:0] ST_RESULT = VS_RESULT;

  localparam int CLS_REJECT = 2;
  localparam int CLS_SPLIT  = 1;
  localparam int CLS_PASS   = 0;

  // REJECT wins over PASS, so the result is one-hot even for odd thresholds.
  function automatic logic [2:0] classify(input int cnt, input int low_max,
                                          input int high_min);
    logic [2:0] c;
    c = '0;
    if (cnt <= low_max)       c[CLS_REJECT] = 1'b1;
    else if (cnt >= high_min) c[CLS_PASS]   = 1'b1;
    else                      c[CLS_SPLIT]  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/voter_popcount.sv
// Combinational population count of a W-bit vector.
module voter_popcount #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/voter_session.sv
// Voting session controller: opens a session, records first ballots, tallies
// and holds a classified result. Optional OPEN timeout under VOTER_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for start
// OPEN      | collecting ballots
// TALLY     | one-cycle count and classification
// RESULT    | result held until accepted
module voter_session
  import voter_pkg::*;
#(
  parameter int N_VOTERS       = 4,
  parameter int LOW_MAX        = 1,
  parameter int HIGH_MIN       = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CW             = $clog2(N_VOTERS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                close,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_yes,
  output logic [N_VOTERS-1:0] voted,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2:0]          res_class,
  output logic [CW-1:0]       yes_cnt,
  output logic                timed_out
);

  if (N_VOTERS < 2 || N_VOTERS > 32) begin : g_bad_n
    $error("voter_session: N_VOTERS out of range");
  end
  if (LOW_MAX < 0 || LOW_MAX >= HIGH_MIN || HIGH_MIN > N_VOTERS) begin : g_bad_thr
    $error("voter_session: thresholds must satisfy LOW_MAX < HIGH_MIN <= N_VOTERS");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("voter_session: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]          state_q, state_d;
  logic [N_VOTERS-1:0] voted_q, voted_d;
  logic [N_VOTERS-1:0] ballot_q, ballot_d;
  logic [N_VOTERS-1:0] new_votes, voted_open;
  logic [CW-1:0]       tally;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          cls_q, cls_d;
  logic                leave_req;
  logic                tmo_fire;

  // Only voters without a recorded ballot may vote; the closing cycle still counts.
  assign new_votes  = vote_valid & ~voted_q;
  assign voted_open = voted_q | new_votes;
  assign leave_req  = close | (&voted_open);

  voter_popcount #(.W(N_VOTERS), .CW(CW)) u_popcount (
    .bits_i (ballot_q),
    .cnt_o  (tally)
  );

  always_comb begin
    state_d  = state_q;
    voted_d  = voted_q;
    ballot_d = ballot_q;
    cnt_d    = cnt_q;
    cls_d    = cls_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_OPEN;
          voted_d  = '0;
          ballot_d = '0;
        end
      end
      ST_OPEN: begin
        voted_d  = voted_open;
        ballot_d = ballot_q | (new_votes & vote_yes);
        if (leave_req || tmo_fire) state_d = ST_TALLY;
      end
      ST_TALLY: begin
        cnt_d   = tally;
        cls_d   = classify(int'(tally), LOW_MAX, HIGH_MIN);
        state_d = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          cls_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      voted_q  <= '0;
      ballot_q <= '0;
      cnt_q    <= '0;
      cls_q    <= '0;
    end else begin
      state_q  <= state_d;
      voted_q  <= voted_d;
      ballot_q <= ballot_d;
      cnt_q    <= cnt_d;
      cls_q    <= cls_d;
    end
  end

`ifdef VOTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          tmo_q, tmo_d;

  // Down-counter loaded on start; terminal count marks the last allowed OPEN cycle.
  assign tmo_fire = (state_q == ST_OPEN) && (tmr_q == '0);

  always_comb begin
    tmr_d = tmr_q;
    tmo_d = tmo_q;
    if (state_q == ST_IDLE && start) begin
      tmr_d = TW'(TIMEOUT_CYCLES - 1);
      tmo_d = 1'b0;
    end else if (state_q == ST_OPEN) begin
      if (tmr_q != '0) tmr_d = tmr_q - TW'(1);
      if (tmo_fire && !leave_req) tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      tmo_q <= tmo_d;
    end
  end

  assign timed_out = res_valid & tmo_q;
`else
  assign tmo_fire  = 1'b0;
  assign timed_out = 1'b0;
`endif

  assign voted     = voted_q;
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_RESULT);
  assign res_class = cls_q;
  assign yes_cnt   = cnt_q;

endmodule

// File: tb/tb_voter_session.sv
// Self-checking bench for voter_session: vector table, directed corner cases
// and randomized sessions against a ballot-level reference model.
module tb_voter_session;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst, start, close, res_ready;
  logic [N-1:0] vote_valid, vote_yes, voted;
  logic         busy, res_valid, timed_out;
  logic [2:0]   res_class;
  logic [2:0]   yes_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  voter_session #(
    .N_VOTERS(N), .LOW_MAX(1), .HIGH_MIN(3), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .close(close),
    .vote_valid(vote_valid), .vote_yes(vote_yes), .voted(voted),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .yes_cnt(yes_cnt), .timed_out(timed_out)
  );

  typedef struct {
    logic [N-1:0] vv;
    logic [N-1:0] vy;
    logic         cl;
    int           ey;
    logic [2:0]   ec;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; close = 0; vote_valid = '0; vote_yes = '0; res_ready = 0;
  endtask

  function automatic logic [2:0] ref_cls(input int y);
    if (y <= 1) return 3'b100;
    if (y >= 3) return 3'b001;
    return 3'b010;
  endfunction

  task automatic check_result(input string nm, input int ey, input logic [2:0] ec,
                              input logic et);
    chk({nm, ".res_valid"}, 32'(res_valid), 32'd1);
    chk({nm, ".yes_cnt"}, 32'(yes_cnt), 32'(ey));
    chk({nm, ".res_class"}, 32'(res_class), 32'(ec));
    chk({nm, ".timed_out"}, 32'(timed_out), 32'(et));
  endtask

  task automatic accept(input string nm);
    res_ready = 1;
    step();
    res_ready = 0;
    chk({nm, ".idle_busy"}, 32'(busy), 32'd0);
    chk({nm, ".idle_res_valid"}, 32'(res_valid), 32'd0);
    chk({nm, ".idle_outs"}, {26'd0, res_class, yes_cnt}, 32'd0);
    chk({nm, ".idle_timed_out"}, 32'(timed_out), 32'd0);
  endtask

  task automatic open_session();
    start = 1;
    step();
    start = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] mv, my;
    logic         cl, ended, texp;
    int           y, maxj, n, h;

    tbl[0] = '{4'hF, 4'h7, 1'b0, 3, 3'b001};
    tbl[1] = '{4'hF, 4'h0, 1'b0, 0, 3'b100};
    tbl[2] = '{4'h5, 4'h5, 1'b1, 2, 3'b010};
    tbl[3] = '{4'h0, 4'hF, 1'b1, 0, 3'b100};
    tbl[4] = '{4'hF, 4'hF, 1'b0, 4, 3'b001};
    tbl[5] = '{4'h6, 4'hF, 1'b1, 2, 3'b010};
    tbl[6] = '{4'h2, 4'hF, 1'b1, 1, 3'b100};
    tbl[7] = '{4'hF, 4'h9, 1'b0, 2, 3'b010};

    idle_in();
    rst = 1;
    step();
    step();
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.voted", 32'(voted), 32'd0);
    chk("reset.res", {26'd0, res_class, yes_cnt}, 32'd0);
    chk("reset.res_valid_to", {30'd0, res_valid, timed_out}, 32'd0);

    // start on the first edge after reset release
    rst = 0;
    start = 1;
    step();
    start = 0;
    chk("post_reset_start.busy", 32'(busy), 32'd1);
    close = 1;
    step();
    close = 0;
    step();
    check_result("post_reset_empty", 0, 3'b100, 1'b0);
    accept("post_reset_empty");

    close = 1;
    step();
    close = 0;
    chk("idle_close_ignored", 32'(busy), 32'd0);

    for (int k = 0; k < 8; k++) begin
      open_session();
      chk($sformatf("tbl%0d.voted_clear", k), 32'(voted), 32'd0);
      vote_valid = tbl[k].vv;
      vote_yes   = tbl[k].vy;
      close      = tbl[k].cl;
      step();
      idle_in();
      chk($sformatf("tbl%0d.voted", k), 32'(voted), 32'(tbl[k].vv));
      chk($sformatf("tbl%0d.tally_no_valid", k), 32'(res_valid), 32'd0);
      step();
      check_result($sformatf("tbl%0d", k), tbl[k].ey, tbl[k].ec, 1'b0);
      accept($sformatf("tbl%0d", k));
    end

    // first ballot wins; start while open is ignored
    open_session();
    vote_valid = 4'h2; vote_yes = 4'h2;
    step();
    start = 1; vote_valid = 4'h2; vote_yes = 4'h2;
    step();
    start = 0; vote_valid = 4'h2; vote_yes = 4'h0;
    step();
    chk("rewrite.voted", 32'(voted), 32'h2);
    chk("rewrite.still_open", {30'd0, busy, res_valid}, 32'b10);
    vote_valid = 4'hD; vote_yes = 4'h0;
    step();
    idle_in();
    chk("rewrite.tally", 32'(res_valid), 32'd0);
    step();
    check_result("rewrite", 1, 3'b100, 1'b0);
    accept("rewrite");

    // close after earlier votes; votes outside OPEN ignored
    open_session();
    vote_valid = 4'h5; vote_yes = 4'h5;
    step();
    idle_in();
    close = 1;
    step();
    close = 0;
    step();
    check_result("early_close", 2, 3'b010, 1'b0);
    vote_valid = 4'hF; vote_yes = 4'hF;
    step();
    chk("result_votes_ignored", 32'(voted), 32'h5);
    vote_valid = 4'h0;
    accept("early_close");
    vote_valid = 4'hF;
    step();
    vote_valid = 4'h0;
    chk("idle_votes_ignored", 32'(voted), 32'h5);

    // result held under backpressure, start ignored
    open_session();
    vote_valid = 4'hF; vote_yes = 4'hF;
    step();
    idle_in();
    step();
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      step();
      check_result($sformatf("hold%0d", c), 4, 3'b001, 1'b0);
    end
    start = 0;
    accept("hold");
    step();
    chk("hold.start_not_queued", 32'(busy), 32'd0);

    // asynchronous reset mid-session
    open_session();
    vote_valid = 4'h3; vote_yes = 4'h1;
    step();
    idle_in();
    chk("abort.voted_before", 32'(voted), 32'h3);
    #3 rst = 1;
    #1;
    chk("abort.voted", 32'(voted), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.res_valid", 32'(res_valid), 32'd0);
    step();
    rst = 0;
    open_session();
    vote_valid = 4'h8; vote_yes = 4'h8; close = 1;
    step();
    idle_in();
    chk("abort.fresh_voted", 32'(voted), 32'h8);
    step();
    check_result("abort.fresh", 1, 3'b100, 1'b0);
    accept("abort.fresh");

`ifdef VOTER_TIMEOUT_EN
    open_session();
    vote_valid = 4'h1; vote_yes = 4'h1;
    step();
    idle_in();
    n = 1;
    while (!res_valid && n < 30) begin
      step();
      n++;
    end
    chk("timeout.latency", 32'(n), 32'd9);
    check_result("timeout", 1, 3'b100, 1'b1);
    accept("timeout");

    open_session();
    for (int c = 0; c < TMO - 1; c++) step();
    chk("tmo_close.open", {30'd0, busy, res_valid}, 32'b10);
    close = 1;
    step();
    close = 0;
    step();
    check_result("tmo_close", 0, 3'b100, 1'b0);
    accept("tmo_close");
`else
    open_session();
    vote_valid = 4'h1; vote_yes = 4'h1;
    step();
    idle_in();
    for (int c = 0; c < 3 * TMO; c++) step();
    chk("no_timeout.open", {30'd0, busy, res_valid}, 32'b10);
    close = 1;
    step();
    close = 0;
    step();
    check_result("no_timeout", 1, 3'b100, 1'b0);
    accept("no_timeout");
`endif

    // randomized sessions against a ballot-level model
    for (int s = 0; s < 40; s++) begin
      mv = '0; my = '0; texp = 0;
      maxj = $urandom_range(1, 12);
      open_session();
      for (int j = 0; j < maxj; j++) begin
        vote_valid = N'($urandom & $urandom);
        vote_yes   = N'($urandom);
        cl         = ($urandom_range(0, 9) == 0) || (j == maxj - 1);
        close      = cl;
        start      = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < N; i++) begin
          if (vote_valid[i] && !mv[i]) begin
            mv[i] = 1'b1;
            my[i] = vote_yes[i];
          end
        end
        ended = cl || (&mv);
`ifdef VOTER_TIMEOUT_EN
        if (!ended && (j + 1 == TMO)) begin
          ended = 1'b1;
          texp  = 1'b1;
        end
`endif
        step();
        chk($sformatf("rnd%0d.voted", s), 32'(voted), 32'(mv));
        if (ended) break;
      end
      idle_in();
      y = 0;
      for (int i = 0; i < N; i++) y += int'(my[i]);
      chk($sformatf("rnd%0d.tally", s), 32'(res_valid), 32'd0);
      step();
      check_result($sformatf("rnd%0d", s), y, ref_cls(y), texp);
      h = $urandom_range(0, 3);
      for (int c = 0; c < h; c++) begin
        step();
        chk($sformatf("rnd%0d.hold", s), {29'd0, res_valid, yes_cnt}, {29'd1, 3'(y)});
      end
      accept($sformatf("rnd%0d", s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
